// File: rtl/wb_rom_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_rom_loader_pkg
//  Purpose  : Register map, STATUS bit positions and FSM states shared by the
//             Wishbone ROM-loader bridge.
//  Revision : 1.0 - initial release
// ============================================================================
package wb_rom_loader_pkg;

  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_DATA   = 4'h4;
  localparam logic [3:0] REG_STATUS = 4'h8;
  localparam logic [3:0] REG_COUNT  = 4'hC;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_FULL    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_TMO     = 4;
  localparam int STAT_LVL_LSB = 8;
  localparam int STAT_LVL_MSB = 12;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_SCK_HI = 2'd2,
    S_SCK_LO = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/rom_loader_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : rom_loader_fifo
//  Purpose  : Synchronous word FIFO with level/full/empty and a flush input.
//  Revision : 1.0 - initial release
// ============================================================================
module rom_loader_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [4:0]       level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [4:0]       level_q, level_d;
  logic             do_push, do_pop;

  assign empty    = (level_q == 5'd0);
  assign full     = (level_q == 5'(DEPTH));
  assign level    = level_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop | flush);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (flush) begin
      level_d = {4'b0, do_push};
    end else if (do_push && !do_pop) begin
      level_d = level_q + 5'd1;
    end else if (do_pop && !do_push) begin
      level_d = level_q - 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_rom_loader_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : wb_rom_loader_bridge
//  Purpose  : Wishbone slave that queues 16-bit words and clocks them into the
//             SoC ROM loader with a four-phase sck/ack handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_rom_loader_bridge
  import wb_rom_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int          FIFO_DEPTH     = 4,
  parameter int          SETUP_CYCLES   = 2,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        rom_loader_load,
  output logic        rom_loader_sck,
  output logic [15:0] rom_loader_data,
  input  logic        rom_loader_ack,
  output logic        irq_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e        state_q, state_d;
  logic          en_q, en_d, irq_en_q, irq_en_d;
  logic          ovf_q, ovf_d, tmo_q, tmo_d;
  logic          sck_q, sck_d, ack_q, ack_d;
  logic [15:0]   count_q, count_d, data_q, data_d;
  logic [31:0]   dat_q, dat_d;
  logic [3:0]    setup_q, setup_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  logic          fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [15:0]   fifo_head;
  logic [4:0]    fifo_level;
  logic          busy, req, wr, tmo_hit, tmo_expired;
  logic [3:0]    off;
  logic [31:0]   status;
  logic          unused_bits;

  assign unused_bits = ^{wbs_sel_i[3:2], wbs_dat_i[31:16]};

  // Requests are ignored in the ack cycle so a held strobe never re-triggers.
  assign req         = wbs_stb_i & wbs_cyc_i & ~ack_q &
                       (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign wr          = req & wbs_we_i;
  assign off         = wbs_adr_i[3:0];
  assign fifo_push   = wr & (off == REG_DATA) & (wbs_sel_i[1:0] == 2'b11);
  assign busy        = (state_q != S_IDLE);
  assign tmo_expired = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  rom_loader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .push      (fifo_push),
    .push_data (wbs_dat_i[15:0]),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_comb begin
    status                             = '0;
    status[STAT_BUSY]                  = busy;
    status[STAT_EMPTY]                 = fifo_empty;
    status[STAT_FULL]                  = fifo_full;
    status[STAT_OVF]                   = ovf_q;
    status[STAT_TMO]                   = tmo_q;
    status[STAT_LVL_MSB:STAT_LVL_LSB]  = fifo_level;
  end

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    irq_en_d   = irq_en_q;
    ovf_d      = ovf_q;
    tmo_d      = tmo_q;
    sck_d      = sck_q;
    count_d    = count_q;
    data_d     = data_q;
    setup_d    = setup_q;
    tmo_cnt_d  = tmo_cnt_q;
    ack_d      = req;
    dat_d      = '0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    tmo_hit    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en_q && !fifo_empty) begin
          fifo_pop = 1'b1;
          data_d   = fifo_head;
          setup_d  = 4'(SETUP_CYCLES);
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        if (setup_q <= 4'd1) begin
          sck_d     = 1'b1;
          tmo_cnt_d = '0;
          state_d   = S_SCK_HI;
        end else begin
          setup_d = setup_q - 4'd1;
        end
      end
      S_SCK_HI: begin
        if (rom_loader_ack) begin
          sck_d     = 1'b0;
          tmo_cnt_d = '0;
          state_d   = S_SCK_LO;
        end else if (tmo_expired) begin
          tmo_hit = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      S_SCK_LO: begin
        if (!rom_loader_ack) begin
          count_d = count_q + 16'd1;
          state_d = S_IDLE;
        end else if (tmo_expired) begin
          tmo_hit = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (tmo_hit) begin
      sck_d      = 1'b0;
      fifo_flush = 1'b1;
      state_d    = S_IDLE;
    end

    // Register writes come after the FSM so an enabling write wins over a
    // COUNT increment landing in the same cycle.
    if (wr && wbs_sel_i[0]) begin
      case (off)
        REG_CTRL: begin
          en_d     = wbs_dat_i[CTRL_EN];
          irq_en_d = wbs_dat_i[CTRL_IRQ_EN];
          if (wbs_dat_i[CTRL_EN] && !en_q) begin
            count_d = '0;
          end
        end
        REG_STATUS: begin
          if (wbs_dat_i[STAT_OVF]) ovf_d = 1'b0;
          if (wbs_dat_i[STAT_TMO]) tmo_d = 1'b0;
        end
        default: ;
      endcase
    end

    if (fifo_push && fifo_full && !fifo_pop && !fifo_flush) begin
      ovf_d = 1'b1;
    end
    if (tmo_hit) begin
      tmo_d = 1'b1;
    end

    if (req && !wbs_we_i) begin
      case (off)
        REG_CTRL:   dat_d = {30'b0, irq_en_q, en_q};
        REG_STATUS: dat_d = status;
        REG_COUNT:  dat_d = {16'b0, count_q};
        default:    dat_d = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      tmo_q     <= 1'b0;
      sck_q     <= 1'b0;
      ack_q     <= 1'b0;
      count_q   <= '0;
      data_q    <= '0;
      dat_q     <= '0;
      setup_q   <= '0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      irq_en_q  <= irq_en_d;
      ovf_q     <= ovf_d;
      tmo_q     <= tmo_d;
      sck_q     <= sck_d;
      ack_q     <= ack_d;
      count_q   <= count_d;
      data_q    <= data_d;
      dat_q     <= dat_d;
      setup_q   <= setup_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign wbs_ack_o       = ack_q;
  assign wbs_dat_o       = dat_q;
  assign rom_loader_sck  = sck_q;
  assign rom_loader_data = data_q;
  assign rom_loader_load = en_q | busy;
  assign irq_o           = irq_en_q & ((en_q & fifo_empty & ~busy) | tmo_q | ovf_q);

endmodule
`default_nettype wire
